// File: rtl/spatz_boot_sequencer.sv
// Boot sequencer: latches an entry point, waits a settle time, writes it to the boot-control
// register over reqrsp, then pulses msip on every core. Optional macro: BOOT_SEQ_TIMEOUT_EN.
module spatz_boot_sequencer #(
  parameter int unsigned          NumCores      = 4,
  parameter int unsigned          AddrWidth     = 48,
  parameter int unsigned          DataWidth     = 64,
  parameter logic [AddrWidth-1:0] BootAddr      = '0,
  parameter int unsigned          WaitCycles    = 1000,
  parameter int unsigned          TimeoutCycles = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [31:0]            entry_point_i,
  output logic [AddrWidth-1:0]   q_addr_o,
  output logic [DataWidth-1:0]   q_data_o,
  output logic                   q_write_o,
  output logic [DataWidth/8-1:0] q_strb_o,
  output logic                   q_valid_o,
  input  logic                   q_ready_i,
  input  logic                   p_valid_i,
  input  logic                   p_error_i,
  output logic                   p_ready_o,
  output logic [NumCores-1:0]    msip_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o
);

  localparam int unsigned WaitW = (WaitCycles > 0) ? $clog2(WaitCycles + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_REQ, S_RESP, S_WAKE, S_DONE
  } state_t;

  state_t           state;
  logic [WaitW-1:0] wait_cnt;
  logic [31:0]      entry;
  logic             done;
  logic             error;
  logic             timeout_hit;

`ifdef BOOT_SEQ_TIMEOUT_EN
  localparam int unsigned ToW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;
  logic [ToW-1:0] to_cnt;

  assign timeout_hit = (to_cnt == '0);

  // The timeout counter is loaded on the request handshake so it covers exactly the RESP cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt <= '0;
    end else if (state == S_REQ && q_ready_i) begin
      to_cnt <= ToW'(TimeoutCycles - 1);
    end else if (state == S_RESP && !timeout_hit) begin
      to_cnt <= to_cnt - ToW'(1);
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = (TimeoutCycles != 0);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      entry    <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            entry <= entry_point_i;
            done  <= 1'b0;
            error <= 1'b0;
            if (WaitCycles == 0) begin
              state <= S_REQ;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= WaitW'(WaitCycles - 1);
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) state <= S_REQ;
          else                wait_cnt <= wait_cnt - WaitW'(1);
        end
        S_REQ: begin
          if (q_ready_i) state <= S_RESP;
        end
        S_RESP: begin
          // A response in the expiry cycle takes priority over the timeout.
          if (p_valid_i) begin
            if (p_error_i) begin
              state <= S_DONE;
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              state <= S_WAKE;
            end
          end else if (timeout_hit) begin
            state <= S_DONE;
            done  <= 1'b1;
            error <= 1'b1;
          end
        end
        S_WAKE: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Everything below is decoded from state and latched data only.
  assign q_valid_o = (state == S_REQ);
  assign q_addr_o  = q_valid_o ? BootAddr : '0;
  assign q_data_o  = q_valid_o ? DataWidth'(entry) : '0;
  assign q_write_o = q_valid_o;
  assign q_strb_o  = {(DataWidth/8){q_valid_o}};
  assign p_ready_o = (state == S_RESP);
  assign msip_o    = {NumCores{state == S_WAKE}};
  assign busy_o    = (state == S_WAIT) || (state == S_REQ) || (state == S_RESP) || (state == S_WAKE);
  assign done_o    = done;
  assign error_o   = error;

endmodule
